// File: rtl/stream_wdt_conv_gen.sv
`default_nettype none
// ============================================================================
// Module      : stream_wdt_conv_gen
// Description : Runtime-configurable N-bit to M-bit stream width converter,
//               LSB-first packing, per-stream config latch, optional padding
//               of the final partial word. Optional statistics counters are
//               enabled by defining STREAM_WDT_CONV_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_wdt_conv_gen #(
    parameter int IN_WORD_WDT  = 64,
    parameter int OUT_WORD_WDT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_en,
    input  logic [$clog2(OUT_WORD_WDT+1)-1:0] cfg_out_wdt,
    input  logic                              cfg_pad_last,
    input  logic                              in_word_valid,
    output logic                              in_word_ready,
    input  logic                              in_word_last,
    input  logic [$clog2(IN_WORD_WDT+1)-1:0]  in_word_val_bits,
    input  logic [IN_WORD_WDT-1:0]            in_word,
    output logic                              out_word_valid,
    input  logic                              out_word_ready,
    output logic                              out_word_last,
    output logic [$clog2(OUT_WORD_WDT+1)-1:0] out_word_val_bits,
    output logic [OUT_WORD_WDT-1:0]           out_word
`ifdef STREAM_WDT_CONV_STAT_EN
    ,
    input  logic                              stat_clr,
    output logic [31:0]                       stat_in_bits,
    output logic [31:0]                       stat_out_words
`endif
);

    localparam int BUFF_WDT = IN_WORD_WDT + OUT_WORD_WDT;
    localparam int c_iw     = $clog2(IN_WORD_WDT + 1);
    localparam int c_ow     = $clog2(OUT_WORD_WDT + 1);
    localparam int c_cw     = $clog2(BUFF_WDT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [BUFF_WDT-1:0] r_buff, w_buff_nxt;
    logic [c_cw-1:0]     r_buff_cnt, w_cnt_nxt;
    logic [c_ow-1:0]     r_out_wdt, w_out_wdt_nxt;
    logic                r_pad, w_pad_nxt;

    logic                w_en;
    logic [c_ow-1:0]     w_cfg_wdt;
    logic [c_iw-1:0]     w_in_bits;
    logic [c_cw-1:0]     w_wdt_cnt;
    logic [c_cw-1:0]     w_cnt_after_out;
    logic                w_run_full;
    logic                w_drain_last;
    logic                w_in_hs;
    logic                w_out_hs;
    logic [OUT_WORD_WDT-1:0] w_out_mask;
    logic [BUFF_WDT-1:0] w_in_ext;
    logic [BUFF_WDT-1:0] w_shifted;
    logic [c_cw-1:0]     w_base;

    assign w_en            = clk_en & ~rst;
    assign w_cfg_wdt       = (cfg_out_wdt == '0 || cfg_out_wdt > c_ow'(OUT_WORD_WDT))
                             ? c_ow'(OUT_WORD_WDT) : cfg_out_wdt;
    assign w_in_bits       = (in_word_val_bits > c_iw'(IN_WORD_WDT))
                             ? c_iw'(IN_WORD_WDT) : in_word_val_bits;
    assign w_wdt_cnt       = c_cw'(r_out_wdt);
    assign w_cnt_after_out = r_buff_cnt - w_wdt_cnt;
    assign w_run_full      = r_buff_cnt >= w_wdt_cnt;
    assign w_drain_last    = r_buff_cnt <= w_wdt_cnt;
    assign w_out_mask      = ~({OUT_WORD_WDT{1'b1}} << r_out_wdt);

    // Output side and input ready. The extra term on the RUN ready keeps a
    // full input word from landing past the buffer top when M < N.
    always_comb begin
        in_word_ready     = 1'b0;
        out_word_valid    = 1'b0;
        out_word_last     = 1'b0;
        out_word_val_bits = '0;
        out_word          = '0;
        case (r_state)
            S_IDLE: begin
                in_word_ready = w_en;
            end
            S_RUN: begin
                out_word_valid = w_en & w_run_full;
                in_word_ready  = w_en & (~w_run_full |
                                 (out_word_ready & (w_cnt_after_out <= c_cw'(OUT_WORD_WDT))));
                if (out_word_valid) begin
                    out_word_val_bits = r_out_wdt;
                    out_word          = r_buff[OUT_WORD_WDT-1:0] & w_out_mask;
                end
            end
            S_DRAIN: begin
                out_word_valid = w_en;
                if (w_en) begin
                    out_word_last = w_drain_last;
                    if (!w_drain_last || r_pad)
                        out_word_val_bits = r_out_wdt;
                    else
                        out_word_val_bits = c_ow'(r_buff_cnt);
                    out_word = r_buff[OUT_WORD_WDT-1:0] & w_out_mask;
                end
            end
            default: ;
        endcase
    end

    assign w_in_hs  = in_word_valid & in_word_ready;
    assign w_out_hs = out_word_valid & out_word_ready;

    assign w_in_ext  = BUFF_WDT'(in_word) & ~({BUFF_WDT{1'b1}} << w_in_bits);
    assign w_shifted = w_out_hs ? (r_buff >> r_out_wdt) : r_buff;
    assign w_base    = w_out_hs ? w_cnt_after_out : r_buff_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_out_wdt_nxt = r_out_wdt;
        w_pad_nxt     = r_pad;
        w_buff_nxt    = w_shifted | (w_in_hs ? (w_in_ext << w_base) : '0);
        w_cnt_nxt     = w_base + (w_in_hs ? c_cw'(w_in_bits) : '0);
        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_out_wdt_nxt = w_cfg_wdt;
                    w_pad_nxt     = cfg_pad_last;
                    w_state_nxt   = in_word_last ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_in_hs && in_word_last)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_out_hs && w_drain_last) begin
                    w_state_nxt = S_IDLE;
                    w_buff_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buff     <= '0;
            r_buff_cnt <= '0;
            r_out_wdt  <= c_ow'(OUT_WORD_WDT);
            r_pad      <= 1'b0;
        end else if (clk_en) begin
            r_state    <= w_state_nxt;
            r_buff     <= w_buff_nxt;
            r_buff_cnt <= w_cnt_nxt;
            r_out_wdt  <= w_out_wdt_nxt;
            r_pad      <= w_pad_nxt;
        end
    end

`ifdef STREAM_WDT_CONV_STAT_EN
    logic [31:0] r_stat_in_bits;
    logic [31:0] r_stat_out_words;
    logic [32:0] w_in_sum;
    logic [32:0] w_out_sum;

    assign w_in_sum  = {1'b0, r_stat_in_bits} + 33'(w_in_bits);
    assign w_out_sum = {1'b0, r_stat_out_words} + 33'd1;

    // Counters saturate rather than wrap; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_in_bits   <= '0;
            r_stat_out_words <= '0;
        end else if (clk_en) begin
            if (stat_clr) begin
                r_stat_in_bits   <= '0;
                r_stat_out_words <= '0;
            end else begin
                if (w_in_hs)
                    r_stat_in_bits <= w_in_sum[32] ? 32'hFFFF_FFFF : w_in_sum[31:0];
                if (w_out_hs)
                    r_stat_out_words <= w_out_sum[32] ? 32'hFFFF_FFFF : w_out_sum[31:0];
            end
        end
    end

    assign stat_in_bits   = r_stat_in_bits;
    assign stat_out_words = r_stat_out_words;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_wdt_conv_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_wdt_conv_gen
// Description : Bench for stream_wdt_conv_gen: bit-queue reference model with
//               per-cycle compare plus directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_wdt_conv_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [6:0]  cfg_out_wdt;
    logic        cfg_pad_last;
    logic        in_word_valid;
    logic        in_word_ready;
    logic        in_word_last;
    logic [6:0]  in_word_val_bits;
    logic [63:0] in_word;
    logic        out_word_valid;
    logic        out_word_ready;
    logic        out_word_last;
    logic [6:0]  out_word_val_bits;
    logic [63:0] out_word;
`ifdef STREAM_WDT_CONV_STAT_EN
    logic        stat_clr;
    logic [31:0] stat_in_bits;
    logic [31:0] stat_out_words;
`endif

    stream_wdt_conv_gen #(.IN_WORD_WDT(64), .OUT_WORD_WDT(64)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cfg_out_wdt(cfg_out_wdt), .cfg_pad_last(cfg_pad_last),
        .in_word_valid(in_word_valid), .in_word_ready(in_word_ready),
        .in_word_last(in_word_last), .in_word_val_bits(in_word_val_bits),
        .in_word(in_word),
        .out_word_valid(out_word_valid), .out_word_ready(out_word_ready),
        .out_word_last(out_word_last), .out_word_val_bits(out_word_val_bits),
        .out_word(out_word)
`ifdef STREAM_WDT_CONV_STAT_EN
        , .stat_clr(stat_clr), .stat_in_bits(stat_in_bits),
        .stat_out_words(stat_out_words)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment: clk_en dropouts and out_word_ready pattern
    int en_rand    = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 never
    int ready_hold = 0;
    always begin
        @(posedge clk);
        #1;
        clk_en = !(en_rand != 0 && $urandom_range(0, 9) == 0);
        if (ready_hold > 0) begin
            out_word_ready = 1'b0;
            ready_hold--;
        end else if (ready_mode == 0)
            out_word_ready = 1'b1;
        else if (ready_mode == 1)
            out_word_ready = ($urandom_range(0, 9) < 7);
        else
            out_word_ready = 1'b0;
    end

    // Reference model: pending stream bits as a queue, LSB first
    bit          mq[$];
    bit          m_active = 0;
    bit          m_drain  = 0;
    int          m_wdt    = 64;
    bit          m_pad    = 0;
    logic [63:0] obs_data[$];
    int          obs_vb[$];
    bit          obs_last[$];

    bit          e_valid, e_last, o_hs, i_hs;
    int          e_vb, nbits, cfgw, ib;
    logic [63:0] e_data;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", 64'(in_word_ready), 64'd0);
            chk("rst_out_valid", 64'(out_word_valid), 64'd0);
            chk("rst_out_last", 64'(out_word_last), 64'd0);
            chk("rst_out_vbits", 64'(out_word_val_bits), 64'd0);
            chk("rst_out_word", out_word, 64'd0);
            mq.delete();
            m_active = 0;
            m_drain  = 0;
            m_wdt    = 64;
            m_pad    = 0;
        end else if (!clk_en) begin
            chk("gated_out_valid", 64'(out_word_valid), 64'd0);
            chk("gated_in_ready", 64'(in_word_ready), 64'd0);
        end else begin
            e_valid = 0; e_last = 0; e_vb = 0; nbits = 0;
            if (!m_active) begin
                chk("idle_in_ready", 64'(in_word_ready), 64'd1);
            end else if (!m_drain) begin
                e_valid = (mq.size() >= m_wdt);
                e_vb    = m_wdt;
                nbits   = m_wdt;
                if (!e_valid)
                    chk("run_in_ready_space", 64'(in_word_ready), 64'd1);
                else if (!out_word_ready)
                    chk("run_in_ready_stall", 64'(in_word_ready), 64'd0);
            end else begin
                e_valid = 1;
                e_last  = (mq.size() <= m_wdt);
                nbits   = e_last ? mq.size() : m_wdt;
                e_vb    = (e_last && m_pad) ? m_wdt : nbits;
                chk("drain_in_ready", 64'(in_word_ready), 64'd0);
            end
            chk("out_valid", 64'(out_word_valid), 64'(e_valid));
            if (e_valid && out_word_valid) begin
                e_data = '0;
                for (int i = 0; i < nbits; i++) e_data[i] = mq[i];
                chk("out_word", out_word, e_data);
                chk("out_vbits", 64'(out_word_val_bits), 64'(e_vb));
                chk("out_last", 64'(out_word_last), 64'(e_last));
            end
            o_hs = e_valid && out_word_valid && out_word_ready;
            i_hs = in_word_valid && in_word_ready;
            if (o_hs) begin
                obs_data.push_back(out_word);
                obs_vb.push_back(int'(out_word_val_bits));
                obs_last.push_back(out_word_last);
                for (int i = 0; i < nbits; i++) void'(mq.pop_front());
                if (m_drain && e_last) begin
                    m_active = 0;
                    m_drain  = 0;
                    mq.delete();
                end
            end
            if (i_hs) begin
                if (!m_active) begin
                    cfgw     = int'(cfg_out_wdt);
                    m_wdt    = (cfgw == 0 || cfgw > 64) ? 64 : cfgw;
                    m_pad    = cfg_pad_last;
                    m_active = 1;
                end
                ib = (int'(in_word_val_bits) > 64) ? 64 : int'(in_word_val_bits);
                for (int i = 0; i < ib; i++) mq.push_back(in_word[i]);
                if (in_word_last) m_drain = 1;
            end
        end
    end

    // Driver tasks are entered and left just after a rising edge
    task automatic send_word(input logic [63:0] d, input int vb, input logic last);
        int  waitc = 0;
        bit  done  = 0;
        in_word          = d;
        in_word_val_bits = 7'(vb);
        in_word_last     = last;
        in_word_valid    = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = in_word_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waitc++;
                if (waitc > 3000) begin
                    chk("send_timeout", 64'd1, 64'd0);
                    done = 1;
                end
            end
        end
        in_word_valid = 1'b0;
        in_word_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int waitc = 0;
        while (m_active) begin
            @(posedge clk);
            #1;
            waitc++;
            if (waitc > 5000) begin
                chk("idle_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_vb.delete();
        obs_last.delete();
    endtask

    task automatic chk_obs(input string name, input int idx, input logic [63:0] d,
                           input int vb, input bit last);
        if (obs_data.size() > idx) begin
            chk({name, "_data"}, obs_data[idx], d);
            chk({name, "_vbits"}, 64'(obs_vb[idx]), 64'(vb));
            chk({name, "_last"}, 64'(obs_last[idx]), 64'(last));
        end
    endtask

    int nw, vb;
    logic [63:0] t1_exp[4];

    initial begin
        rst = 1'b1; clk_en = 1'b1; out_word_ready = 1'b1;
        cfg_out_wdt = '0; cfg_pad_last = 1'b0;
        in_word_valid = 1'b0; in_word_last = 1'b0; in_word_val_bits = '0; in_word = '0;
`ifdef STREAM_WDT_CONV_STAT_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: 64-bit word split into four 16-bit words
        t1_exp[0] = 64'hCDEF; t1_exp[1] = 64'h89AB; t1_exp[2] = 64'h4567; t1_exp[3] = 64'h0123;
        clear_obs();
        cfg_out_wdt = 7'd16; cfg_pad_last = 1'b0;
        send_word(64'h0123_4567_89AB_CDEF, 64, 1'b1);
        wait_idle();
        chk("t1_count", 64'(obs_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_obs("t1", i, t1_exp[i], 16, (i == 3));
`ifdef STREAM_WDT_CONV_STAT_EN
        chk("t1_stat_in_bits", 64'(stat_in_bits), 64'd64);
        chk("t1_stat_out_words", 64'(stat_out_words), 64'd4);
        stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        chk("stat_clr_in_bits", 64'(stat_in_bits), 64'd0);
`endif

        // 2: partial final word, unpadded then padded
        for (int p = 0; p < 2; p++) begin
            clear_obs();
            cfg_out_wdt = 7'd48; cfg_pad_last = p[0];
            send_word(64'hFFFF_FFFF_FFFF_FFAA, 8, 1'b0);
            send_word(64'h0000_0000_0000_00BB, 8, 1'b0);
            send_word(64'h1234_0000_0000_00CC, 8, 1'b1);
            wait_idle();
            chk("t2_count", 64'(obs_data.size()), 64'd1);
            chk_obs("t2", 0, 64'hCC_BBAA, (p == 0) ? 24 : 48, 1'b1);
        end

        // 3: config change mid-stream is ignored until the next stream
        clear_obs();
        cfg_out_wdt = 7'd16; cfg_pad_last = 1'b0;
        send_word(64'h1111_2222_3333_4444, 64, 1'b0);
        cfg_out_wdt = 7'd32;
        send_word(64'hFFFF_FFFF_FFFF_5555, 16, 1'b1);
        wait_idle();
        chk("t3_count", 64'(obs_data.size()), 64'd5);
        chk_obs("t3_w0", 0, 64'h4444, 16, 1'b0);
        chk_obs("t3_w3", 3, 64'h1111, 16, 1'b0);
        chk_obs("t3_w4", 4, 64'h5555, 16, 1'b1);
        clear_obs();
        send_word(64'hDEAD_BEEF_CAFE_F00D, 64, 1'b1);
        wait_idle();
        chk("t3b_count", 64'(obs_data.size()), 64'd2);
        chk_obs("t3b_w0", 0, 64'hCAFE_F00D, 32, 1'b0);
        chk_obs("t3b_w1", 1, 64'hDEAD_BEEF, 32, 1'b1);

        // 4: empty last word
        clear_obs();
        cfg_out_wdt = 7'd32; cfg_pad_last = 1'b0;
        send_word(64'hFFFF, 0, 1'b1);
        wait_idle();
        chk("t4_count", 64'(obs_data.size()), 64'd1);
        chk_obs("t4", 0, 64'd0, 0, 1'b1);
        @(negedge clk);
        chk("t4_idle_ready", 64'(in_word_ready), 64'd1);
        chk("t4_idle_valid", 64'(out_word_valid), 64'd0);
        @(posedge clk); #1;

        // 5: back-pressure with random val_bits at M=32
        ready_mode = 1;
        ready_hold = 10;
        cfg_out_wdt = 7'd32; cfg_pad_last = 1'b0;
        for (int w = 0; w < 10; w++)
            send_word({$urandom, $urandom}, $urandom_range(0, 64), (w == 9));
        wait_idle();

        // 6: reset while draining 40 buffered bits
        ready_mode = 2;
        cfg_out_wdt = 7'd64;
        send_word(64'h00AB_CDEF_0123_4567, 40, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_post_rst_valid", 64'(out_word_valid), 64'd0);
        chk("t6_post_rst_ready", 64'(in_word_ready), 64'd1);
        @(posedge clk); #1;
        ready_mode = 0;
        clear_obs();
        cfg_out_wdt = 7'd16;
        send_word(64'h9999_0000_0000_ABCD, 16, 1'b1);
        wait_idle();
        chk("t6_count", 64'(obs_data.size()), 64'd1);
        chk_obs("t6", 0, 64'hABCD, 16, 1'b1);

        // Random streams: random widths, pads, clamping, gaps, clk_en and ready
        en_rand = 1;
        ready_mode = 1;
        for (int s = 0; s < 40; s++) begin
            nw = $urandom_range(1, 8);
            cfg_out_wdt  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                        : 7'($urandom_range(1, 64));
            cfg_pad_last = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                vb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 64);
                send_word({$urandom, $urandom}, vb, (w == nw - 1));
                cfg_out_wdt  = 7'($urandom_range(0, 127));
                cfg_pad_last = 1'($urandom_range(0, 1));
            end
            wait_idle();
        end
        en_rand = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
